// File: rtl/uart_pkg.sv
// uart_pkg: shared types and reset constants for the UART TX scheduler.
// Optional parity (8E1) framing is enabled by UART_TX_SCHED_PARITY_EN.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      BAUD_19200  = 2'b00,
      BAUD_38400  = 2'b01,
      BAUD_57600  = 2'b10,
      BAUD_115200 = 2'b11
   } baud_sel_e;

`ifdef UART_TX_SCHED_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_SYNC, ST_START, ST_DATA, ST_PARITY, ST_STOP
   } tx_state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_SYNC, ST_START, ST_DATA, ST_STOP
   } tx_state_e;
`endif

   localparam logic      TX_IDLE      = 1'b1;
   localparam baud_sel_e BAUD_SEL_RST = BAUD_19200;

endpackage

// File: rtl/uart_rr_arb.sv
// uart_rr_arb: round-robin arbiter, search starts one past the last winner.
// Pointer resets to NREQ-1 so index 0 has first priority.
module uart_rr_arb #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic            clkin_gated,
   input  logic            rst,
   input  logic [NREQ-1:0] req_i,
   input  logic            adv_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o
);

   logic [IW-1:0] ptr_q;
   logic          found;
   int            j;

   // Pointer moves to the winner whenever a grant is taken.
   always_ff @(posedge clkin_gated or posedge rst) begin
      if (rst) ptr_q <= IW'(NREQ - 1);
      else if (adv_i) ptr_q <= idx_o;
   end

   // First valid request after the pointer, wrapping around.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         j = (int'(ptr_q) + k) % NREQ;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART TX line among NREQ byte requesters.
// Define UART_TX_SCHED_PARITY_EN for 8E1 frames (default 8N1).
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8
) (
   input  logic                     clkin_gated,
   input  logic                     rst,
   input  logic                     baud_clk,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     cfg_wr,
   input  logic [1:0]               cfg_baud_sel,
   output logic [1:0]               baud_sel,
   output logic                     tx,
   output logic                     busy,
   output logic [$clog2(NREQ)-1:0]  grant_id
);

   localparam int IW = $clog2(NREQ);
   localparam logic [2:0] LAST = 3'(UART_DATA_BITS - 1);

   tx_state_e                 state_q, state_d;
   logic                      baud_q;
   logic                      tick;
   logic                      tx_q, tx_d;
   logic                      busy_q, busy_d;
   logic [NREQ-1:0]           rdy_q, rdy_d;
   baud_sel_e                 bsel_q, bsel_d;
   logic                      pend_q, pend_d;
   baud_sel_e                 pval_q, pval_d;
   logic [IW-1:0]             gid_q, gid_d;
   logic [UART_DATA_BITS-1:0] sh_q, sh_d;
   logic [2:0]                cnt_q, cnt_d;
   logic                      adv;
   logic [NREQ-1:0]           gnt;
   logic [IW-1:0]             gidx;

   assign tick = baud_clk & ~baud_q;

   uart_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
      .clkin_gated (clkin_gated),
      .rst         (rst),
      .req_i       (req_valid),
      .adv_i       (adv),
      .gnt_o       (gnt),
      .idx_o       (gidx)
   );

   // State, line and configuration registers.
   always_ff @(posedge clkin_gated or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         baud_q  <= 1'b0;
         tx_q    <= TX_IDLE;
         busy_q  <= 1'b0;
         rdy_q   <= '0;
         bsel_q  <= BAUD_SEL_RST;
         pend_q  <= 1'b0;
         pval_q  <= BAUD_SEL_RST;
         gid_q   <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_clk;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         rdy_q   <= rdy_d;
         bsel_q  <= bsel_d;
         pend_q  <= pend_d;
         pval_q  <= pval_d;
         gid_q   <= gid_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
      end
   end

   // Frame sequencing; rate changes are applied only from IDLE.
   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      rdy_d   = '0;
      bsel_d  = bsel_q;
      pend_d  = pend_q;
      pval_d  = pval_q;
      gid_d   = gid_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      adv     = 1'b0;
      if (cfg_wr) begin
         pend_d = 1'b1;
         pval_d = baud_sel_e'(cfg_baud_sel);
      end
      unique case (state_q)
         ST_IDLE: begin
            if (pend_q) begin
               bsel_d = pval_q;
               if (!cfg_wr) pend_d = 1'b0;
            end else if (|req_valid) begin
               adv     = 1'b1;
               rdy_d   = gnt;
               sh_d    = req_data[int'(gidx)*DATA_W +: DATA_W];
               gid_d   = gidx;
               busy_d  = 1'b1;
               state_d = ST_SYNC;
            end
         end
         ST_SYNC: begin
            tx_d = TX_IDLE;
            if (tick) begin
               tx_d    = 1'b0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               tx_d    = sh_q[0];
               cnt_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (cnt_q != LAST) begin
                  // Rotate so the byte stays intact for parity.
                  sh_d  = {sh_q[0], sh_q[UART_DATA_BITS-1:1]};
                  tx_d  = sh_q[1];
                  cnt_d = cnt_q + 3'd1;
               end else begin
`ifdef UART_TX_SCHED_PARITY_EN
                  tx_d    = ^sh_q;
                  state_d = ST_PARITY;
`else
                  tx_d    = TX_IDLE;
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_SCHED_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               tx_d    = TX_IDLE;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign tx        = tx_q;
   assign busy      = busy_q;
   assign req_ready = rdy_q;
   assign baud_sel  = bsel_q;
   assign grant_id  = gid_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed checks of framing, fairness, config and reset.
// Define UART_TX_SCHED_PARITY_EN to also exercise 8E1 framing.
module tb_uart_tx_sched;

`ifdef UART_TX_SCHED_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        baud_clk = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic        cfg_wr = 1'b0;
   logic [1:0]  cfg_baud_sel = '0;
   logic [1:0]  baud_sel;
   logic        tx;
   logic        busy;
   logic [1:0]  grant_id;

   int n_tests = 0;
   int n_fail  = 0;
   int rdy_pulses = 0;
   int gq[$];
   bit saw01 = 1'b0;

   uart_tx_sched dut (
      .clkin_gated  (clk),
      .rst          (rst),
      .baud_clk     (baud_clk),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .cfg_wr       (cfg_wr),
      .cfg_baud_sel (cfg_baud_sel),
      .baud_sel     (baud_sel),
      .tx           (tx),
      .busy         (busy),
      .grant_id     (grant_id)
   );

   always #5 clk = ~clk;
   always #40 baud_clk = ~baud_clk;

   always @(negedge clk) begin
      if (!rst && req_ready != 4'b0) begin
         rdy_pulses++;
         gq.push_back(int'(grant_id));
      end
      if (baud_sel == 2'b01) saw01 = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NB-1:0] frm(input logic [7:0] d);
`ifdef UART_TX_SCHED_PARITY_EN
      return {1'b1, ^d, d, 1'b0};
`else
      return {1'b1, d, 1'b0};
`endif
   endfunction

   task automatic wait_ready(input logic [3:0] exp, input string tag);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready != 4'b0) break;
      end
      chk(tag, 32'(req_ready), 32'(exp));
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic chk_frame(input logic [7:0] d, input string tag);
      logic [NB-1:0] v0, v1;
      bit found;
      found = 1'b0;
      v0 = '0;
      v1 = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx == 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         chk({tag, " start"}, 32'(tx), 32'd0);
      end else begin
         for (int c = 0; c < NB*8-1; c++) begin
            if (c % 8 == 1) v0[c/8] = tx;
            if (c % 8 == 6) v1[c/8] = tx;
            @(negedge clk);
         end
         chk({tag, " early"}, 32'(v0), 32'(frm(d)));
         chk({tag, " late"}, 32'(v1), 32'(frm(d)));
      end
   endtask

   initial begin
      bit bad;
      logic [7:0] fb [5];
      int fg [5];
      fb = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      fg = '{0, 1, 2, 3, 0};

      // reset values
      repeat (3) @(negedge clk);
      chk("rst tx", 32'(tx), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst ready", 32'(req_ready), 32'd0);
      chk("rst baud_sel", 32'(baud_sel), 32'd0);
      chk("rst grant_id", 32'(grant_id), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // fairness: all four requesting
      gq.delete();
      req_data = 32'h13121110;
      req_valid = 4'b1111;
      for (int f = 0; f < 5; f++) chk_frame(fb[f], "rr frame");
      req_valid = 4'b0000;
      wait_idle("rr idle");
      chk("rr count", 32'(gq.size()), 32'd5);
      for (int f = 0; f < 5; f++)
         if (f < gq.size()) chk("rr order", 32'(gq[f]), 32'(fg[f]));

      // single frame 0xA5 from requester 0
      rdy_pulses = 0;
      req_data[7:0] = 8'hA5;
      req_valid = 4'b0001;
      wait_ready(4'b0001, "a5 ready");
      req_valid = 4'b0000;
      chk_frame(8'hA5, "a5 frame");
      wait_idle("a5 idle");
      chk("a5 pulses", 32'(rdy_pulses), 32'd1);

`ifdef UART_TX_SCHED_PARITY_EN
      // parity bits
      req_data[7:0] = 8'h07;
      req_valid = 4'b0001;
      wait_ready(4'b0001, "p07 ready");
      req_valid = 4'b0000;
      chk_frame(8'h07, "p07 frame");
      wait_idle("p07 idle");
      req_data[7:0] = 8'h03;
      req_valid = 4'b0001;
      wait_ready(4'b0001, "p03 ready");
      req_valid = 4'b0000;
      chk_frame(8'h03, "p03 frame");
      wait_idle("p03 idle");
`endif

      // config staged during DATA, applied between frames
      req_data[7:0] = 8'h3C;
      req_data[15:8] = 8'h5A;
      req_valid = 4'b0001;
      wait_ready(4'b0001, "cfg ready0");
      req_valid = 4'b0010;
      repeat (30) @(negedge clk);
      cfg_baud_sel = 2'b11;
      cfg_wr = 1'b1;
      @(negedge clk);
      cfg_wr = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 150 && busy; i++) begin
         if (baud_sel != 2'b00) bad = 1'b1;
         @(negedge clk);
      end
      chk("cfg held", 32'(bad), 32'd0);
      chk("cfg idle", 32'(busy), 32'd0);
      chk("cfg n0 sel", 32'(baud_sel), 32'd0);
      @(negedge clk);
      chk("cfg n1 sel", 32'(baud_sel), 32'd3);
      chk("cfg n1 busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("cfg n2 busy", 32'(busy), 32'd1);
      chk("cfg n2 ready", 32'(req_ready), 32'b0010);
      req_valid = 4'b0000;

      // overwrite within one frame
      repeat (20) @(negedge clk);
      cfg_baud_sel = 2'b01;
      cfg_wr = 1'b1;
      @(negedge clk);
      cfg_wr = 1'b0;
      repeat (10) @(negedge clk);
      cfg_baud_sel = 2'b10;
      cfg_wr = 1'b1;
      @(negedge clk);
      cfg_wr = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 150 && busy; i++) begin
         if (baud_sel != 2'b11) bad = 1'b1;
         @(negedge clk);
      end
      chk("ovr held", 32'(bad), 32'd0);
      chk("ovr idle", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("ovr sel", 32'(baud_sel), 32'd2);
      chk("ovr no 01", 32'(saw01), 32'd0);

      // reset in the middle of data bit 3 of 0xFF
      req_data[7:0] = 8'hFF;
      req_valid = 4'b0001;
      wait_ready(4'b0001, "mid ready");
      bad = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx == 1'b0) begin
            bad = 1'b0;
            break;
         end
      end
      chk("mid start", 32'(bad), 32'd0);
      repeat (35) @(negedge clk);
      chk("mid busy pre", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid tx", 32'(tx), 32'd1);
      chk("mid busy", 32'(busy), 32'd0);
      chk("mid ready", 32'(req_ready), 32'd0);
      chk("mid baud_sel", 32'(baud_sel), 32'd0);
      chk("mid grant_id", 32'(grant_id), 32'd0);
      req_valid = 4'b0101;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_ready(4'b0001, "post ready0");
      chk("post gid0", 32'(grant_id), 32'd0);
      req_valid = 4'b0100;
      wait_ready(4'b0100, "post ready2");
      chk("post gid2", 32'(grant_id), 32'd2);
      req_valid = 4'b0000;
      wait_idle("post idle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
